// File: rtl/regfile_wb_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_wb_controller: round-robin ALU/load write-back arbiter driving the
// register-file write port, plus a per-register busy scoreboard for issue.
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_wb_controller #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [WIDTH-1:0]       alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ADDR_W-1:0]      ld_rd,
  input  logic [WIDTH-1:0]       ld_data,
  output logic                   rf_write,
  output logic [ADDR_W-1:0]      rf_write_register,
  output logic [WIDTH-1:0]       rf_write_data,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_rd,
  input  logic [ADDR_W-1:0]      rs1,
  input  logic [ADDR_W-1:0]      rs2,
  output logic                   operand_stall,
  output logic [2**ADDR_W-1:0]   busy
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} src_e;

  src_e              last_winner_q;
  logic              rf_write_q;
  logic [ADDR_W-1:0] rf_reg_q;
  logic [WIDTH-1:0]  rf_data_q;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  logic              alu_xfer;
  logic              ld_xfer;
  logic              wb_write;
  logic [ADDR_W-1:0] wb_rd;
  logic [WIDTH-1:0]  wb_data;

  // Contention goes to whichever source did not win the last transfer.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (!rst) begin
      if (alu_valid && ld_valid) begin
        if (last_winner_q == SRC_LD) alu_ready = 1'b1;
        else                         ld_ready  = 1'b1;
      end else begin
        alu_ready = alu_valid;
        ld_ready  = ld_valid;
      end
    end
  end

  assign alu_xfer = alu_valid && alu_ready;
  assign ld_xfer  = ld_valid && ld_ready;
  assign wb_rd    = alu_xfer ? alu_rd   : ld_rd;
  assign wb_data  = alu_xfer ? alu_data : ld_data;
  assign wb_write = (alu_xfer || ld_xfer) && (wb_rd != '0);

  // Clear first, then set, so a same-edge reservation keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_write)
      busy_d[wb_rd] = 1'b0;
    if (rsv_valid && (rsv_rd != '0))
      busy_d[rsv_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_q    <= 1'b0;
      rf_reg_q      <= '0;
      rf_data_q     <= '0;
      busy_q        <= '0;
      last_winner_q <= SRC_LD;
    end else begin
      rf_write_q <= wb_write;
      if (wb_write) begin
        rf_reg_q  <= wb_rd;
        rf_data_q <= wb_data;
      end
      busy_q <= busy_d;
      if (alu_xfer)
        last_winner_q <= SRC_ALU;
      else if (ld_xfer)
        last_winner_q <= SRC_LD;
    end
  end

  assign rf_write          = rf_write_q;
  assign rf_write_register = rf_reg_q;
  assign rf_write_data     = rf_data_q;
  assign busy              = busy_q;
  assign operand_stall     = ((rs1 != '0) && busy_q[rs1]) || ((rs2 != '0) && busy_q[rs2]);

endmodule
`default_nettype wire

// File: doc/regfile_wb_controller.md
REGFILE_WB_CONTROLLER -- requirements
Module: regfile_wb_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of one register.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; NREG = 2**ADDR_W registers.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports alu_valid  input  1 / alu_ready  output  1 / alu_rd  input  ADDR_W / alu_data  input  WIDTH  ALU write-back request.
REQ-006 SHALL have ports ld_valid  input  1 / ld_ready  output  1 / ld_rd  input  ADDR_W / ld_data  input  WIDTH  load-unit write-back request.
REQ-007 SHALL have ports rf_write  output  1 / rf_write_register  output  ADDR_W / rf_write_data  output  WIDTH  registered drive of the register file write port.
REQ-008 SHALL have ports rsv_valid  input  1 / rsv_rd  input  ADDR_W  destination reservation at instruction issue.
REQ-009 SHALL have ports rs1, rs2  input  ADDR_W  source operands of the instruction being issued.
REQ-010 SHALL have port operand_stall  output  1  issue must hold because a source is pending.
REQ-011 SHALL have port busy  output  NREG  scoreboard bit per register.

Function
REQ-012 Transfer SHALL occur on a source when valid && ready at a rising edge; a source SHALL hold rd/data stable while valid && !ready.
REQ-013 ready SHALL be combinational: at most one of alu_ready/ld_ready high per cycle, both low while rst is high.
REQ-014 Single valid requester SHALL be granted in the same cycle.
REQ-015 Both valid: grant SHALL go to the source that did not win the most recent transfer (round-robin, 1-bit last_winner).
REQ-016 last_winner SHALL update on every transfer to the transferring source; no update on idle cycles.
REQ-017 Accepted request SHALL appear on rf_write/rf_write_register/rf_write_data exactly one cycle after the transfer edge (latency 1), rf_write high for one cycle per transfer.
REQ-018 Back-to-back transfers SHALL give rf_write high on consecutive cycles; throughput one write per cycle.
REQ-019 Transfer with rd == 0 SHALL be accepted (ready high) but SHALL leave rf_write low next cycle and SHALL not change busy.
REQ-020 Cycle with no transfer SHALL drive rf_write low next cycle; rf_write_register/rf_write_data hold last value.
REQ-021 busy[r] SHALL set at the edge where rsv_valid && rsv_rd == r, r != 0.
REQ-022 busy[r] SHALL clear at the transfer edge of a write-back with rd == r, r != 0.
REQ-023 Set and clear of the same r at the same edge: set SHALL win (busy stays 1).
REQ-024 busy[0] SHALL be constant 0.
REQ-025 operand_stall SHALL be combinational: (rs1 != 0 && busy[rs1]) || (rs2 != 0 && busy[rs2]), from current busy (no same-cycle bypass of a clear).
REQ-026 Reservation of an already-busy register SHALL leave it busy (no counting); one write-back clears it.

Reset
REQ-027 While rst high at an edge: rf_write=0, rf_write_register=0, rf_write_data=0, busy=all 0, last_winner=LOAD (so ALU wins first contention).
REQ-028 Requests valid during reset SHALL not transfer; reset mid-operation SHALL drop the pending rf_write of the previous cycle's transfer (rf_write 0 the cycle after reset edge).
REQ-029 Reservations and write-backs presented during reset SHALL be ignored.

Verification
REQ-030 Reset then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF one cycle -> alu_ready=1 that cycle; next cycle rf_write=1, rf_write_register=5, rf_write_data=0xDEADBEEF; following cycle rf_write=0.
REQ-031 After reset, alu and ld both valid for 3 cycles (rd 1 and 2, held) -> grants ALU, LOAD, ALU; rf_write_register 1,2,1 on cycles +1..+3.
REQ-032 rsv_valid=1, rsv_rd=7; next cycle rs1=7 -> busy[7]=1, operand_stall=1; ld write-back rd=7 -> busy[7]=0 and operand_stall=0 the cycle after transfer.
REQ-033 Same edge: rsv_rd=9 and alu transfer rd=9 with busy[9]=1 -> busy[9] remains 1; rsv_rd=0 -> busy unchanged.
REQ-034 ld transfer rd=0, data=0x1234 -> ld_ready=1, rf_write stays 0, busy unchanged; rs1=0, rs2=0 -> operand_stall=0.
REQ-035 alu transfer rd=3 then rst high next edge -> rf_write=0 after reset edge, busy all 0, next contention granted to ALU.
